// File: rtl/xd_pkg.sv
// Shared types for the cross-domain pulse pacer and its synchroniser.
package xd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } pacer_state_t;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/xd_pulse_pacer.sv
// Source-domain pacer: queues event pulses and re-emits them at least GAP apart.
// Optional XD_PULSE_PACER_DROP_CNT_EN adds a saturating dropped-event counter.
module xd_pulse_pacer
    import xd_pkg::*;
#(
    parameter int GAP    = 8,
    parameter int DEPTH  = 15,
    parameter int PEND_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i,
    output logic              o,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
`ifdef XD_PULSE_PACER_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic              overflow
);

    if (GAP < 2 || GAP > 255) begin : g_gap_chk
        $error("xd_pulse_pacer: GAP must be in 2..255");
    end
    if (DEPTH < 1 || DEPTH > 65535) begin : g_depth_chk
        $error("xd_pulse_pacer: DEPTH must be in 1..65535");
    end

    localparam logic [7:0]        GAP_LOAD = 8'(GAP - 2);
    localparam logic [PEND_W-1:0] FULL     = PEND_W'(DEPTH);

    pacer_state_t state;
    logic [7:0]   timer;
    logic         take;
    logic         has_pend;
    logic         drop;

    assign has_pend = (pending != '0);
    assign take     = (state == IDLE) && (i || has_pend);
    // A consume on the same cycle frees a slot, so only a non-take cycle can drop.
    assign drop     = !take && i && (pending == FULL);
    assign busy     = has_pend || o || (state == WAIT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            timer    <= '0;
            o        <= 1'b0;
            overflow <= 1'b0;
            pending  <= '0;
        end else begin
            o        <= take;
            overflow <= drop;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state <= WAIT;
                        timer <= GAP_LOAD;
                    end
                end
                WAIT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (take && has_pend) begin
                if (!i) begin
                    pending <= pending - 1'b1;
                end
            end else if (!take && i && (pending != FULL)) begin
                pending <= pending + 1'b1;
            end
        end
    end

`ifdef XD_PULSE_PACER_DROP_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xd_pulse_pacer.sv
// Randomised and directed checks of xd_pulse_pacer against a cycle-count model.
module tb_xd_pulse_pacer;

    localparam int GAP   = 8;
    localparam int DEPTH = 15;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i = 1'b0;
    logic          o;
    logic          busy;
    logic          ovf;
    logic [PW-1:0] pending;
`ifdef XD_PULSE_PACER_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    xd_pulse_pacer #(.GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .i        (i),
        .o        (o),
        .pending  (pending),
        .busy     (busy),
`ifdef XD_PULSE_PACER_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .overflow (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit valid = 0;

    // Model: backlog count plus the cycle of the most recent output pulse.
    int m_pend;
    bit m_o;
    bit m_ovf;
    int m_last;
    int m_drop;

    logic       o_log [0:255];
    logic       b_log [0:255];
    logic       v_log [0:255];
    int         p_log [0:255];
    int         d_log [0:255];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic run(bit iv, bit rv);
        bit take;
        bit drop;
        bit m_busy;
        i     = iv;
        rst_n = rv;
        @(negedge clk);
        m_busy = (m_pend != 0) || m_o ||
                 (cyc >= m_last && cyc <= m_last + GAP - 2);
        if (valid) begin
            chk("o", 32'(o), 32'(m_o));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overflow", 32'(ovf), 32'(m_ovf));
`ifdef XD_PULSE_PACER_DROP_CNT_EN
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        end
        if (cyc >= 0 && cyc < 256) begin
            o_log[cyc] = o;
            b_log[cyc] = busy;
            v_log[cyc] = ovf;
            p_log[cyc] = int'(pending);
`ifdef XD_PULSE_PACER_DROP_CNT_EN
            d_log[cyc] = int'(drop_cnt);
`else
            d_log[cyc] = 0;
`endif
        end
        @(posedge clk);
        if (!rv) begin
            m_pend = 0;
            m_o    = 0;
            m_ovf  = 0;
            m_last = -1000;
            m_drop = 0;
            valid  = 1;
        end else begin
            take = (cyc >= m_last + GAP - 1) && (iv || m_pend > 0);
            drop = !take && iv && (m_pend == DEPTH);
            if (take && m_pend > 0) m_pend = m_pend - 1 + int'(iv);
            else if (!take && iv && m_pend < DEPTH) m_pend++;
            m_o   = take;
            m_ovf = drop;
            if (take) m_last = cyc + 1;
            if (drop && m_drop < 65535) m_drop++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        cyc = -3;
        for (int k = 0; k < 3; k++) run(1'b0, 1'b0);
    endtask

    task automatic scen(int lo, int hi, int len);
        do_reset();
        for (int c = 0; c < len; c++) run(c >= lo && c <= hi, 1'b1);
    endtask

    function automatic int o_count(int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (o_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int o_on_grid(int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++)
            if (o_log[c] === 1'b1 && c >= 11 && (c - 11) % GAP == 0) n++;
        return n;
    endfunction

    int n_ovf;
    int maxp;
    int dens;

    initial begin
        // Single event
        scen(10, 10, 40);
        chk("reset_pending", 32'(p_log[0]), 32'd0);
        chk("reset_busy", 32'(b_log[0]), 32'd0);
        chk("single_o11", 32'(o_log[11]), 32'd1);
        chk("single_count", 32'(o_count(0, 39)), 32'd1);
        chk("single_busy11", 32'(b_log[11]), 32'd1);
        chk("single_busy17", 32'(b_log[17]), 32'd1);
        chk("single_busy19", 32'(b_log[19]), 32'd0);
        maxp = 0;
        n_ovf = 0;
        for (int c = 0; c < 40; c++) begin
            if (p_log[c] > maxp) maxp = p_log[c];
            if (v_log[c] === 1'b1) n_ovf++;
        end
        chk("single_pend_max", 32'(maxp), 32'd0);
        chk("single_ovf", 32'(n_ovf), 32'd0);

        // Burst of three
        scen(10, 12, 40);
        chk("burst_o11", 32'(o_log[11]), 32'd1);
        chk("burst_o19", 32'(o_log[19]), 32'd1);
        chk("burst_o27", 32'(o_log[27]), 32'd1);
        chk("burst_count", 32'(o_count(0, 39)), 32'd3);
        chk("burst_p12", 32'(p_log[12]), 32'd1);
        chk("burst_p13", 32'(p_log[13]), 32'd2);
        chk("burst_p20", 32'(p_log[20]), 32'd1);
        chk("burst_p28", 32'(p_log[28]), 32'd0);

        // Overflow: 20 events, two dropped
        scen(10, 29, 200);
        chk("ovf_p28", 32'(p_log[28]), 32'd15);
        chk("ovf_v28", 32'(v_log[28]), 32'd0);
        chk("ovf_v29", 32'(v_log[29]), 32'd1);
        chk("ovf_v30", 32'(v_log[30]), 32'd1);
        chk("ovf_v31", 32'(v_log[31]), 32'd0);
        chk("ovf_o_count", 32'(o_count(0, 199)), 32'd18);
        chk("ovf_o_grid", 32'(o_on_grid(0, 199)), 32'd18);
        chk("ovf_p_end", 32'(p_log[199]), 32'd0);
`ifdef XD_PULSE_PACER_DROP_CNT_EN
        chk("drop_cnt31", 32'(d_log[31]), 32'd2);
        chk("drop_cnt_held", 32'(d_log[199]), 32'd2);
        do_reset();
        run(1'b0, 1'b1);
        chk("drop_cnt_reset", 32'(d_log[0]), 32'd0);
`endif

        // Coincident consume and event while full
        scen(10, 34, 60);
        chk("full_p34", 32'(p_log[34]), 32'd15);
        chk("full_o35", 32'(o_log[35]), 32'd1);
        chk("full_p35", 32'(p_log[35]), 32'd15);
        chk("full_v34", 32'(v_log[34]), 32'd1);
        chk("full_v35", 32'(v_log[35]), 32'd0);

        // Reset mid-backlog
        do_reset();
        for (int c = 0; c < 17; c++) run(c >= 10 && c <= 16, 1'b1);
        run(1'b0, 1'b0);
        for (int c = 0; c < 40; c++) run(1'b0, 1'b1);
        chk("rst_p17", 32'(p_log[17]), 32'd6);
        chk("rst_o18", 32'(o_log[18]), 32'd0);
        chk("rst_p18", 32'(p_log[18]), 32'd0);
        chk("rst_b18", 32'(b_log[18]), 32'd0);
        chk("rst_no_o", 32'(o_count(18, 57)), 32'd0);

        // Random traffic with varying density and sporadic resets
        do_reset();
        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                run($urandom_range(0, 99) < dens, $urandom_range(0, 499) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
